btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front-end for the stopwatch control buttons (clear, stop, lap, start). Sits directly upstream of the stopwatch core's BTN0..BTN3 inputs.
- Synchronises raw pad inputs and debounces each channel independently.
- Emits a clean level plus single-cycle press/release strobes, so the core acts once per physical press rather than on every bounce or every held cycle.

Parameters:
- N_BTN, 4, number of independent button channels
- DEBOUNCE_CYCLES, 120000, cycles an input must be stable before accepted (10 ms at 12 MHz); legal range 2..2^CNT_W-1
- CNT_W, 17, width of per-channel stability counter
- REPEAT_DELAY, 6000000, cycles held before first auto-repeat (optional feature only)
- REPEAT_PERIOD, 1200000, cycles between auto-repeat strobes (optional feature only)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- btn_raw  in  N_BTN  raw, asynchronous, active-high button pads
- btn_level  out  N_BTN  debounced button level
- btn_press  out  N_BTN  one-cycle strobe on accepted press (and on auto-repeat when enabled)
- btn_release  out  N_BTN  one-cycle strobe on accepted release

Behaviour:
- Interface: one clock, CLK. RST is asynchronous and active-high; it clears all state immediately and releases synchronously to CLK.
- Reset values:
  - btn_level = 0, btn_press = 0, btn_release = 0
  - sync flops = 0, counters = 0, every channel FSM in IDLE_LO
- Sync: btn_raw passes through a 2-flop synchroniser per bit. "s" denotes the second-stage output.
- Per-channel FSM states:
  - IDLE_LO: level 0. On s=1, go to ARM_HI with cnt=1.
  - ARM_HI: if s=0, return to IDLE_LO with cnt=0 (bounce rejected). Otherwise cnt++. When s=1 and cnt==DEBOUNCE_CYCLES-1, go to HELD; level goes to 1; btn_press pulses for exactly 1 cycle.
  - HELD: level 1. On s=0, go to ARM_LO with cnt=1.
  - ARM_LO: mirror of ARM_HI. If s=1, return to HELD. When s=0 and cnt==DEBOUNCE_CYCLES-1, go to IDLE_LO; level goes to 0; btn_release pulses for 1 cycle.
- Outputs are registered. btn_level and its strobe change on the same edge.
- Latency: with btn_raw rising before edge k and stable thereafter, btn_level/btn_press assert after edge k+1+DEBOUNCE_CYCLES. Release latency is identical.
- A glitch shorter than DEBOUNCE_CYCLES produces no level change and no strobe.
- Counter never wraps. It is only compared while the state is ARM_HI or ARM_LO and never exceeds DEBOUNCE_CYCLES-1.
- Channels are fully independent. Simultaneous presses on several channels produce strobes in the same cycle. No priority is applied here; priority is the core's concern.
- Reset mid-operation: any in-progress arm is discarded and no strobe is emitted. If btn_raw is still high after reset release, it is treated as a new press and btn_press fires after full latency.
- btn_press and btn_release for a channel are never asserted in the same cycle.
- Minimum spacing between any two strobes on one channel is DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter (width sized for REPEAT_DELAY), cleared on entry to HELD.
  - While in HELD or ARM_LO, once REPEAT_DELAY cycles have elapsed since the accepted press, btn_press re-pulses. It then re-pulses every REPEAT_PERIOD cycles.
  - Repeats stop on entry to IDLE_LO, or on return from ARM_LO to HELD only if the release was accepted; a rejected release bounce does not restart the delay.
- Undefined: REPEAT_DELAY and REPEAT_PERIOD are unused, no repeat counters are synthesised, and there is exactly one btn_press per accepted press.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10 in sim):
- Clean press: btn_raw[0] rises and holds 50 cycles. Required: btn_level[0]=1 and btn_press[0] high for exactly 1 cycle, 9 edges after the first sampling edge. No other channel strobes.
- Bounce: btn_raw[2] toggles 1,0,1,0 with 3-cycle high/low segments, then holds 1. Required: exactly one btn_press[2], 9 edges after the final rise.
- Release: after a held press, btn_raw[2] drops with a 4-cycle bounce high mid-way. Required: exactly one btn_release[2], timed from the last fall; btn_level[2]=0 after it.
- Simultaneous: btn_raw=4'b1010 asserted on the same edge. Required: btn_press=4'b1010 on a single cycle.
- Reset mid-arm: btn_raw[1]=1 for 5 cycles, RST pulsed asynchronously (between edges), then RST released with btn_raw[1] still 1. Required: all outputs 0 immediately during RST; a single btn_press[1] occurs 9 edges after release; no strobe before.
- With BTN_AUTOREPEAT_EN, btn_raw[3] held 100 cycles. Required: btn_press[3] at acceptance, then at +40, +50, +60, +70, +80, +90 cycles. After btn_raw falls: one btn_release[3] and no further btn_press[3]. Without the macro: exactly one btn_press[3].

Source files
------------

// File: rtl/btn_conditioner.sv
// Button front-end: 2-flop synchroniser plus per-channel debounce FSM with registered level/press/release.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat press strobes.

module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE_LO,
        ARM_HI,
        HELD,
        ARM_LO
    } chanState_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifndef BTN_AUTOREPEAT_EN
    logic unusedRepeatParams;
    assign unusedRepeatParams = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    for (genvar ch = 0; ch < N_BTN; ch++) begin : gChan
        chanState_e       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             sNow;
        logic             releaseAccept;

        assign sNow          = sync2_q[ch];
        assign releaseAccept = (state_q == ARM_LO) && !sNow && (cnt_q == CntLast);

`ifdef BTN_AUTOREPEAT_EN
        localparam int RptW = $clog2(REPEAT_DELAY + 1);

        logic [RptW-1:0] rpt_q;
        logic            rptActive;
        logic            rptFire;

        // Repeat age keeps running through a rejected release bounce; only a press acceptance clears it.
        assign rptActive = (state_q == HELD) || (state_q == ARM_LO);
        assign rptFire   = rptActive && (rpt_q == RptW'(REPEAT_DELAY - 1));
`endif

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q   <= IDLE_LO;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q     <= '0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    IDLE_LO: begin
                        if (sNow) begin
                            state_q <= ARM_HI;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ARM_HI: begin
                        if (!sNow) begin
                            state_q <= IDLE_LO;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sNow) begin
                            state_q <= ARM_LO;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ARM_LO: begin
                        if (sNow) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (releaseAccept) begin
                            state_q   <= IDLE_LO;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE_LO;
                        cnt_q   <= '0;
                    end
                endcase
`ifdef BTN_AUTOREPEAT_EN
                if (rptActive && !releaseAccept) begin
                    if (rptFire) begin
                        press_q <= 1'b1;
                        rpt_q   <= RptW'(REPEAT_DELAY - REPEAT_PERIOD);
                    end else begin
                        rpt_q <= rpt_q + 1'b1;
                    end
                end
`endif
            end
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner with a queue scoreboard.
// The reference model treats debouncing as "input differs from accepted level for N consecutive samples".

module tb_btn_conditioner;

    localparam int NBtn      = 4;
    localparam int Deb       = 8;
    localparam int RptDelay  = 40;
    localparam int RptPeriod = 10;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HoldPressCount = 7;
`else
    localparam int HoldPressCount = 1;
`endif

    typedef struct packed {
        logic [NBtn-1:0] level;
        logic [NBtn-1:0] press;
        logic [NBtn-1:0] rel;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NBtn-1:0] btn_raw = '0;
    logic [NBtn-1:0] btn_level;
    logic [NBtn-1:0] btn_press;
    logic [NBtn-1:0] btn_release;

    int checks   = 0;
    int failures = 0;

    exp_t            expQ[$];
    logic [NBtn-1:0] rawHist[$];
    logic [NBtn-1:0] modelLevel = '0;
    int              runLen[NBtn];
    int              age[NBtn];
    int              pressCount[NBtn];
    int              releaseCount[NBtn];
    int              simulHits = 0;
    logic [NBtn-1:0] randRaw = '0;

    btn_conditioner #(
        .N_BTN          (NBtn),
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (17),
        .REPEAT_DELAY   (RptDelay),
        .REPEAT_PERIOD  (RptPeriod)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NBtn-1:0] value, input int cycles);
        @(negedge CLK);
        btn_raw = value;
        repeat (cycles) @(posedge CLK);
    endtask

    task automatic clearCounts();
        for (int c = 0; c < NBtn; c++) begin
            pressCount[c]   = 0;
            releaseCount[c] = 0;
        end
        simulHits = 0;
    endtask

    task automatic pulseReset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 checkOutput("outputs during reset", int'({btn_level, btn_press, btn_release}), 0);
        @(negedge CLK);
        #2 RST = 1'b0;
    endtask

    // Reference model: each edge pushes the outputs expected right after that edge.
    always @(posedge CLK) begin : refModel
        exp_t            e;
        logic [NBtn-1:0] s;
        e = '0;
        if (RST) begin
            rawHist    = '{'0, '0};
            modelLevel = '0;
            for (int c = 0; c < NBtn; c++) begin
                runLen[c] = 0;
                age[c]    = 0;
            end
        end else begin
            rawHist.push_back(btn_raw);
            s = rawHist.pop_front();
            for (int c = 0; c < NBtn; c++) begin
                if (s[c] != modelLevel[c]) runLen[c]++;
                else runLen[c] = 0;
                if (runLen[c] == Deb) begin
                    runLen[c]     = 0;
                    modelLevel[c] = s[c];
                    if (s[c]) begin
                        e.press[c] = 1'b1;
                        age[c]     = 0;
                    end else begin
                        e.rel[c] = 1'b1;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (modelLevel[c]) begin
                    age[c]++;
                    if (age[c] >= RptDelay && ((age[c] - RptDelay) % RptPeriod) == 0)
                        e.press[c] = 1'b1;
                end
`endif
            end
            e.level = modelLevel;
        end
        expQ.push_back(e);
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("level/press/release", int'({btn_level, btn_press, btn_release}), int'(e));
            for (int c = 0; c < NBtn; c++) begin
                if (btn_press[c]) pressCount[c]++;
                if (btn_release[c]) releaseCount[c]++;
            end
            if (btn_press == 4'b1010) simulHits++;
        end
    end

    initial begin
        for (int c = 0; c < NBtn; c++) begin
            runLen[c] = 0;
            age[c]    = 0;
        end
        clearCounts();
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        applyStimulus('0, 5);

        // Clean press and release on channel 0
        clearCounts();
        applyStimulus(4'b0001, 50);
        applyStimulus(4'b0000, 20);
        @(negedge CLK); #1;
        checkOutput("clean press count ch0", pressCount[0], 1);
        checkOutput("clean release count ch0", releaseCount[0], 1);
        checkOutput("clean press other channels", pressCount[1] + pressCount[2] + pressCount[3], 0);

        // Bouncy press on channel 2, then bouncy release
        clearCounts();
        applyStimulus(4'b0100, 3);
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0100, 3);
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0100, 30);
        @(negedge CLK); #1;
        checkOutput("bounce press count ch2", pressCount[2], 1);
        checkOutput("bounce level ch2", int'(btn_level[2]), 1);
        clearCounts();
        applyStimulus(4'b0000, 3);
        applyStimulus(4'b0100, 4);
        applyStimulus(4'b0000, 20);
        @(negedge CLK); #1;
        checkOutput("bounce release count ch2", releaseCount[2], 1);
        checkOutput("bounce release extra press ch2", pressCount[2], 0);
        checkOutput("level ch2 after release", int'(btn_level[2]), 0);

        // Simultaneous presses
        clearCounts();
        applyStimulus(4'b1010, 20);
        applyStimulus(4'b0000, 20);
        @(negedge CLK); #1;
        checkOutput("simultaneous strobe cycles", simulHits, 1);
        checkOutput("simultaneous press ch1", pressCount[1], 1);
        checkOutput("simultaneous press ch3", pressCount[3], 1);

        // Reset in the middle of an arm, with channel 0 already held
        applyStimulus(4'b0001, 20);
        applyStimulus(4'b0011, 5);
        pulseReset();
        clearCounts();
        applyStimulus(4'b0011, 30);
        @(negedge CLK); #1;
        checkOutput("post-reset press ch0", pressCount[0], 1);
        checkOutput("post-reset press ch1", pressCount[1], 1);
        applyStimulus(4'b0000, 20);

        // Long hold on channel 3 (auto-repeat when enabled)
        clearCounts();
        applyStimulus(4'b1000, 100);
        applyStimulus(4'b0000, 30);
        @(negedge CLK); #1;
        checkOutput("hold press count ch3", pressCount[3], HoldPressCount);
        checkOutput("hold release count ch3", releaseCount[3], 1);

        // Random bouncing on all channels, with one reset in the middle
        randRaw = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NBtn; c++)
                if ($urandom_range(0, 9) == 0) randRaw[c] = ~randRaw[c];
            if (cyc == 1000) pulseReset();
            applyStimulus(randRaw, 1);
        end
        applyStimulus('0, 30);
        @(negedge CLK); #1;
        checkOutput("final level idle", int'(btn_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
